serializer_64bit: RTL and testbench

Parallel-to-serial converter directly downstream of the 64-bit data register; it consumes that register's data_out word and shifts it out one bit per enabled cycle.
- Valid/ready handshake on the parallel side.
- One-entry holding buffer, so back-to-back words stream with no idle gap.
- Framing strobes (first/last) on the serial side, for a downstream line driver or CRC stage.

---
 rtl/serializer_pkg.sv | 19 +
 rtl/serializer_64bit_hold_buffer.sv | 31 +++
 rtl/serializer_64bit.sv | 95 +++++++++
 tb/tb_serializer_64bit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the 64-bit parallel-to-serial converter.
// Imported by the top-level serializer and its hold buffer.
package serializer_pkg;

   localparam int WIDTH_DEFAULT = 64;

   // Counter width for a given word width; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/serializer_64bit_hold_buffer.sv
// One-entry holding register that parks a word accepted while the shifter is busy.
// The top guarantees a write only when empty and a read only when full.
module hold_buffer
   import serializer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] data,
   output logic             full,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full <= 1'b0;
         q    <= '0;
      end else begin
         if (wr_en) begin
            full <= 1'b1;
            q    <= data;
         end else if (rd_en) begin
            full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serializer_64bit.sv
// Parallel-to-serial converter with valid/ready intake, a one-word hold buffer
// for gapless streaming, and first/last framing strobes on the serial side.
module serializer_64bit
   import serializer_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEFAULT,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last,
   output logic             busy
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

   ser_state_t       state;
   logic [WIDTH-1:0] shifter;
   logic [CW-1:0]    count;
   logic             hold_full;
   logic [WIDTH-1:0] hold_q;

   logic accept;
   logic consume;
   logic last_consume;
   logic bypass;
   logic hold_wr;
   logic hold_rd;

   // in_ready depends only on the hold flag, so it never combinationally follows in_valid.
   assign in_ready     = !hold_full;
   assign accept       = in_valid && in_ready;
   assign consume      = (state == SHIFT) && shift_en;
   assign last_consume = consume && (count == LAST_IDX);
   assign bypass       = accept && !hold_full && ((state == IDLE) || last_consume);
   assign hold_wr      = accept && !bypass;
   assign hold_rd      = last_consume && hold_full;

   hold_buffer #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk   (clk),
      .reset (reset),
      .wr_en (hold_wr),
      .rd_en (hold_rd),
      .data  (data_in),
      .full  (hold_full),
      .q     (hold_q)
   );

   // A held word always wins over a new bypass word at a frame boundary; the two
   // cannot coincide anyway because a full hold forces in_ready low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shifter <= '0;
         count   <= '0;
      end else begin
         if (hold_rd) begin
            shifter <= hold_q;
            count   <= '0;
            state   <= SHIFT;
         end else if (bypass) begin
            shifter <= data_in;
            count   <= '0;
            state   <= SHIFT;
         end else if (last_consume) begin
            shifter <= '0;
            count   <= '0;
            state   <= IDLE;
         end else if (consume) begin
            if (MSB_FIRST)
               shifter <= {shifter[WIDTH-2:0], 1'b0};
            else
               shifter <= {1'b0, shifter[WIDTH-1:1]};
            count <= count + 1'b1;
         end
      end
   end

   assign ser_out   = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];
   assign ser_valid = (state == SHIFT);
   assign ser_first = ser_valid && (count == '0);
   assign ser_last  = ser_valid && (count == LAST_IDX);
   assign busy      = (state == SHIFT) || hold_full;

endmodule

// File: tb/tb_serializer_64bit.sv
// Directed bench for serializer_64bit: framing, back-to-back hold, stalls,
// asynchronous reset, LSB-first order and hold back-pressure.
module tb_serializer_64bit;

   localparam int W = 64;

   logic          clk;
   logic          reset;
   logic [W-1:0]  data_in;
   logic          in_valid;
   logic          shift_en;
   logic          in_ready, ser_out, ser_valid, ser_first, ser_last, busy;
   logic          in_ready_l, ser_out_l, ser_valid_l, ser_first_l, ser_last_l, busy_l;

   int            n_checks;
   int            n_fail;

   logic          bit_rec   [0:255];
   logic          bit_rec_l [0:255];
   logic [3:0]    flag_rec  [0:255];

   serializer_64bit #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .shift_en  (shift_en),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .ser_first (ser_first),
      .ser_last  (ser_last),
      .busy      (busy)
   );

   serializer_64bit #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready_l),
      .shift_en  (shift_en),
      .ser_out   (ser_out_l),
      .ser_valid (ser_valid_l),
      .ser_first (ser_first_l),
      .ser_last  (ser_last_l),
      .busy      (busy_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [W-1:0] d, input logic v, input logic s);
      data_in  = d;
      in_valid = v;
      shift_en = s;
   endtask

   // Outputs are looked at 1 time unit after the rising edge, inputs changed there too.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int idx);
      bit_rec[idx]   = ser_out;
      bit_rec_l[idx] = ser_out_l;
      flag_rec[idx]  = {in_ready, ser_last, ser_first, ser_valid};
   endtask

   function automatic logic [63:0] word_at(input int base, input bit lsb_inst);
      logic [63:0] w;
      w = '0;
      for (int k = 0; k < 64; k++) begin
         if (lsb_inst) w[k] = bit_rec_l[base + k];
         else          w[63 - k] = bit_rec[base + k];
      end
      return w;
   endfunction

   // Flag bit index: 0 valid, 1 first, 2 last, 3 in_ready.
   function automatic int count_flag(input int lo, input int hi, input int b, input logic v);
      int c;
      c = 0;
      for (int i = lo; i <= hi; i++) if (flag_rec[i][b] === v) c++;
      return c;
   endfunction

   function automatic int find_flag(input int lo, input int hi, input int b);
      for (int i = lo; i <= hi; i++) if (flag_rec[i][b] === 1'b1) return i;
      return -1;
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   stall_bad;
      int   n;
      logic saved_en;

      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      apply_stimulus('0, 1'b0, 1'b1);

      // Reset state
      #3;
      check_output("rst_ser_out",   ser_out,   0);
      check_output("rst_ser_valid", ser_valid, 0);
      check_output("rst_ser_first", ser_first, 0);
      check_output("rst_ser_last",  ser_last,  0);
      check_output("rst_busy",      busy,      0);
      check_output("rst_in_ready",  in_ready,  1);
      tick;
      reset = 1'b0;
      tick;

      // Test 1: single word 9, MSB first
      $display("[TB] test 1: single frame");
      apply_stimulus(64'd9, 1'b1, 1'b1);
      tick;
      apply_stimulus('0, 1'b0, 1'b1);
      check_output("t1_valid_lat", ser_valid, 1);
      check_output("t1_first_lat", ser_first, 1);
      for (int i = 0; i < 64; i++) begin
         sample(i);
         tick;
      end
      check_output("t1_word",      word_at(0, 0),           64'd9);
      check_output("t1_valid_cnt", count_flag(0, 63, 0, 1), 64);
      check_output("t1_first_cnt", count_flag(0, 63, 1, 1), 1);
      check_output("t1_first_pos", find_flag(0, 63, 1),     0);
      check_output("t1_last_pos",  find_flag(0, 63, 2),     63);
      check_output("t1_idle",      ser_valid,               0);
      check_output("t1_busy",      busy,                    0);

      // Test 2: back-to-back words 1 and 2
      $display("[TB] test 2: back-to-back");
      apply_stimulus(64'd1, 1'b1, 1'b1);
      tick;
      sample(0);
      apply_stimulus(64'd2, 1'b1, 1'b1);
      tick;
      apply_stimulus('0, 1'b0, 1'b1);
      for (int i = 1; i < 128; i++) begin
         sample(i);
         tick;
      end
      check_output("t2_word0",      word_at(0, 0),            64'd1);
      check_output("t2_word1",      word_at(64, 0),           64'd2);
      check_output("t2_valid_cnt",  count_flag(0, 127, 0, 1), 128);
      check_output("t2_notready",   count_flag(0, 127, 3, 0), 63);
      check_output("t2_first_cnt",  count_flag(0, 127, 1, 1), 2);
      check_output("t2_first2_pos", find_flag(1, 127, 1),     64);
      check_output("t2_last_pos",   find_flag(0, 127, 2),     63);
      check_output("t2_last_bit",   bit_rec[127],             0);
      check_output("t2_idle",       ser_valid,                0);

      // Test 3: word 5 with a 5-cycle stall at bit 10
      $display("[TB] test 3: stall");
      apply_stimulus(64'd5, 1'b1, 1'b1);
      tick;
      stall_bad = 0;
      n = 0;
      for (int c = 0; c < 69; c++) begin
         saved_en = !(c >= 10 && c < 15);
         apply_stimulus('0, 1'b0, saved_en);
         if (saved_en) begin
            sample(n);
            n++;
         end else if ({ser_out, ser_valid, ser_first, ser_last} !== 4'b0100) begin
            stall_bad++;
         end
         tick;
      end
      shift_en = 1'b1;
      check_output("t3_stall_frozen", stall_bad,               0);
      check_output("t3_word",         word_at(0, 0),           64'd5);
      check_output("t3_valid_cnt",    count_flag(0, 63, 0, 1), 64);
      check_output("t3_last_pos",     find_flag(0, 63, 2),     63);
      check_output("t3_idle",         ser_valid,               0);

      // Test 4: asynchronous reset mid-frame, then a clean frame
      $display("[TB] test 4: async reset");
      apply_stimulus(64'd3, 1'b1, 1'b1);
      tick;
      apply_stimulus('0, 1'b0, 1'b1);
      repeat (20) tick;
      check_output("t4_pre_valid", ser_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      check_output("t4_rst_valid", ser_valid, 0);
      check_output("t4_rst_out",   ser_out,   0);
      check_output("t4_rst_busy",  busy,      0);
      check_output("t4_rst_ready", in_ready,  1);
      tick;
      reset = 1'b0;
      tick;
      check_output("t4_no_resume", busy, 0);
      apply_stimulus(64'd4, 1'b1, 1'b1);
      tick;
      apply_stimulus('0, 1'b0, 1'b1);
      for (int i = 0; i < 64; i++) begin
         sample(i);
         tick;
      end
      check_output("t4_word",      word_at(0, 0),           64'd4);
      check_output("t4_first_pos", find_flag(0, 63, 1),     0);
      check_output("t4_valid_cnt", count_flag(0, 63, 0, 1), 64);
      check_output("t4_idle",      ser_valid,               0);

      // Test 5: LSB-first instance, word 5
      $display("[TB] test 5: lsb first");
      apply_stimulus(64'd5, 1'b1, 1'b1);
      tick;
      apply_stimulus('0, 1'b0, 1'b1);
      for (int i = 0; i < 64; i++) begin
         sample(i);
         tick;
      end
      check_output("t5_first3", {bit_rec_l[0], bit_rec_l[1], bit_rec_l[2]}, 3'b101);
      check_output("t5_word",   word_at(0, 1),                              64'd5);
      check_output("t5_idle",   ser_valid_l,                                0);

      // Test 6: in_valid held high against a full hold
      $display("[TB] test 6: hold back-pressure");
      apply_stimulus(64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1);
      tick;
      sample(0);
      apply_stimulus(64'h8000_0000_0000_0001, 1'b1, 1'b1);
      tick;
      for (int i = 1; i < 192; i++) begin
         sample(i);
         if (i <= 64) apply_stimulus(64'h1000 + 64'(i), 1'b1, 1'b1);
         else         apply_stimulus('0, 1'b0, 1'b1);
         tick;
      end
      check_output("t6_word_a",    word_at(0, 0),            64'hDEAD_BEEF_0123_4567);
      check_output("t6_word_b",    word_at(64, 0),           64'h8000_0000_0000_0001);
      check_output("t6_word_c",    word_at(128, 0),          64'h1040);
      check_output("t6_ready_ret", flag_rec[64][3],          1);
      check_output("t6_notready",  count_flag(0, 191, 3, 0), 126);
      check_output("t6_valid_cnt", count_flag(0, 191, 0, 1), 192);
      check_output("t6_idle",      busy,                     0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
